// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: owns the PC, keeps one fetch in flight and hands each
// fetched word to decode over valid/ready; execute redirects override everything.
module ysyx_23060332_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        fetch_err_o
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ibuf_q, ibuf_d;
    logic              discard_q, discard_d;
    logic              req_en_q;

    logic              req_fire;
    logic              jump_bad;

    // Requests are held off until the first edge after reset release.
    assign imem_req_valid = req_en_q & (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid_o   = (state_q == S_HOLD) & ~jump_flag_i;
    assign inst_o         = ibuf_q;
    assign inst_addr_o    = pc_q;
    assign fetch_err_o    = (state_q == S_ERR);

    assign req_fire = imem_req_valid & imem_req_ready;
    assign jump_bad = (jump_addr_i[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            ibuf_q    <= '0;
            discard_q <= 1'b0;
            req_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ibuf_q    <= ibuf_d;
            discard_q <= discard_d;
            req_en_q  <= 1'b1;
        end
    end

    // Next state: a redirect wins over handshakes and responses in the same cycle.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ibuf_d    = ibuf_q;
        discard_d = discard_q;
        unique case (state_q)
            S_REQ: begin
                if (jump_flag_i) begin
                    if (jump_bad) begin
                        state_d = S_ERR;
                    end else begin
                        pc_d = jump_addr_i;
                        if (req_fire) begin
                            state_d   = S_WAIT;
                            discard_d = 1'b1;
                        end
                    end
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (jump_flag_i) begin
                    if (jump_bad) begin
                        state_d = S_ERR;
                    end else begin
                        pc_d = jump_addr_i;
                        if (imem_rsp_valid) begin
                            state_d   = S_REQ;
                            discard_d = 1'b0;
                        end else begin
                            discard_d = 1'b1;
                        end
                    end
                end else if (imem_rsp_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else if (imem_rsp_err) begin
                        state_d = S_ERR;
                    end else begin
                        ibuf_d  = imem_rsp_data;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (jump_flag_i) begin
                    if (jump_bad) begin
                        state_d = S_ERR;
                    end else begin
                        pc_d    = jump_addr_i;
                        state_d = S_REQ;
                    end
                end else if (inst_ready_i) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Randomized bench for the fetch unit: a flag-based fetch model predicts every
// output each cycle, with literal checks pinning reset, sequencing and faults.
module tb_ysyx_23060332_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        fetch_err_o;

    ysyx_23060332_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o),
        .inst_ready_i   (inst_ready_i),
        .jump_flag_i    (jump_flag_i),
        .jump_addr_i    (jump_addr_i),
        .fetch_err_o    (fetch_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural model: what the fetch unit is currently doing, as plain flags.
    logic        m_en, m_err, m_busy, m_stale, m_have;
    logic [31:0] m_pc, m_inst;

    // Memory side: at most one accepted request awaiting its response.
    logic        mem_pend;
    int          mem_wait;

    logic        zw;
    logic        force_j;
    logic [31:0] force_addr;

    int          req_cyc[$];
    logic [31:0] req_adr[$];
    int          iv_cyc[$];
    logic [31:0] iv_adr[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_stale = 1'b0; m_have = 1'b0;
        m_pc = 32'h8000_0000; m_inst = 32'h0;
        mem_pend = 1'b0; mem_wait = 0;
    endtask

    task automatic check_reset_literals();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err_o), 32'd0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_inst_addr", inst_addr_o, 32'h8000_0000);
    endtask

    // One clock: drive at the falling edge, check, advance model before the rising edge.
    task automatic cycle();
        logic e_req;
        logic e_iv;
        if (zw) begin
            imem_req_ready = 1'b1;
            imem_rsp_valid = mem_pend;
            imem_rsp_data  = 32'h0010_0093;
            imem_rsp_err   = 1'b0;
            inst_ready_i   = 1'b1;
            jump_flag_i    = 1'b0;
            jump_addr_i    = 32'h0;
        end else begin
            imem_req_ready = ($urandom % 3) != 0;
            imem_rsp_valid = mem_pend && (mem_wait == 0) && (($urandom % 4) != 0);
            imem_rsp_data  = $urandom;
            imem_rsp_err   = imem_rsp_valid && (($urandom % 150) == 0);
            inst_ready_i   = ($urandom % 3) != 0;
            jump_flag_i    = ($urandom % 9) == 0;
            jump_addr_i    = 32'h8000_0000 + 32'($urandom_range(0, 255)) * 32'd4;
            if (($urandom % 120) == 0) jump_addr_i[1:0] = 2'($urandom_range(1, 3));
        end
        if (force_j) begin
            jump_flag_i = 1'b1;
            jump_addr_i = force_addr;
        end
        #1;
        e_req = m_en && !m_err && !m_busy && !m_have;
        e_iv  = m_have && !jump_flag_i && !m_err;
        chk("req_valid", 32'(imem_req_valid), 32'(e_req));
        if (e_req) chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", 32'(inst_valid_o), 32'(e_iv));
        chk("inst", inst_o, m_inst);
        chk("inst_addr", inst_addr_o, m_pc);
        chk("fetch_err", 32'(fetch_err_o), 32'(m_err));

        if (zw && rst_n) begin
            if (imem_req_valid && imem_req_ready) begin
                req_cyc.push_back(cyc); req_adr.push_back(imem_req_addr);
            end
            if (inst_valid_o && inst_ready_i) begin
                iv_cyc.push_back(cyc); iv_adr.push_back(inst_addr_o);
            end
        end

        if (rst_n) begin
            if (!m_err) begin
                if (jump_flag_i) begin
                    if (jump_addr_i[1:0] != 2'b00) begin
                        m_err = 1'b1; m_busy = 1'b0; m_have = 1'b0; m_stale = 1'b0;
                    end else begin
                        m_pc = jump_addr_i;
                        if (m_have) m_have = 1'b0;
                        else if (m_busy) begin
                            if (imem_rsp_valid) begin m_busy = 1'b0; m_stale = 1'b0; end
                            else m_stale = 1'b1;
                        end else if (e_req && imem_req_ready) begin
                            m_busy = 1'b1; m_stale = 1'b1;
                        end
                    end
                end else if (m_have) begin
                    if (inst_ready_i) begin m_have = 1'b0; m_pc = m_pc + 32'd4; end
                end else if (m_busy) begin
                    if (imem_rsp_valid) begin
                        m_busy = 1'b0;
                        if (m_stale) m_stale = 1'b0;
                        else if (imem_rsp_err) m_err = 1'b1;
                        else begin m_have = 1'b1; m_inst = imem_rsp_data; end
                    end
                end else if (e_req && imem_req_ready) begin
                    m_busy = 1'b1;
                end
            end
            m_en = 1'b1;

            if (imem_rsp_valid) mem_pend = 1'b0;
            else if (mem_pend && mem_wait > 0) mem_wait--;
            if (imem_req_valid && imem_req_ready) begin
                mem_pend = 1'b1;
                mem_wait = $urandom_range(0, 3);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // Assert reset between edges, preferably while a fetch is in flight.
    task automatic reset_mid_wait();
        for (int i = 0; i < 40 && !m_busy; i++) cycle();
        #2 rst_n = 1'b0;
        #1 check_reset_literals();
        model_reset();
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; zw = 1'b0; force_j = 1'b0; force_addr = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        imem_rsp_err = 1'b0; inst_ready_i = 1'b0; jump_flag_i = 1'b0; jump_addr_i = 32'h0;
        model_reset();
        @(negedge clk);
        #1 check_reset_literals();
        @(negedge clk);
        cycle();
        cycle();

        // Zero-wait memory, decode always ready.
        zw = 1'b1;
        rst_n = 1'b1;
        begin
            int rel;
            rel = cyc;
            repeat (12) cycle();
            chk("zw_req_count_ge3", 32'(req_cyc.size() >= 3), 32'd1);
            chk("zw_iv_count_ge2", 32'(iv_cyc.size() >= 2), 32'd1);
            if (req_cyc.size() >= 3 && iv_cyc.size() >= 2) begin
                chk("zw_first_req_latency", 32'(req_cyc[0] - rel), 32'd1);
                chk("zw_req0", req_adr[0], 32'h8000_0000);
                chk("zw_req1", req_adr[1], 32'h8000_0004);
                chk("zw_req2", req_adr[2], 32'h8000_0008);
                chk("zw_spacing01", 32'(req_cyc[1] - req_cyc[0]), 32'd3);
                chk("zw_spacing12", 32'(req_cyc[2] - req_cyc[1]), 32'd3);
                chk("zw_iv0_addr", iv_adr[0], 32'h8000_0000);
                chk("zw_iv1_addr", iv_adr[1], 32'h8000_0004);
                chk("zw_iv0_latency", 32'(iv_cyc[0] - req_cyc[0]), 32'd2);
            end
        end

        // Misaligned redirect locks the unit up.
        force_j = 1'b1; force_addr = 32'h8000_0102;
        cycle();
        force_j = 1'b0;
        #1;
        chk("misalign_err", 32'(fetch_err_o), 32'd1);
        chk("misalign_no_req", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        repeat (4) cycle();
        zw = 1'b0;

        for (int r = 0; r < 10; r++) begin
            reset_mid_wait();
            repeat (300) cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060332_ifu.md
# ysyx_23060332_ifu

Instruction fetch unit: holds the architectural PC, issues one fetch at a time to instruction memory and presents the fetched word with its address to the decode stage through a valid/ready handshake. It sits directly upstream of decode, which takes `inst_o`/`inst_addr_o`. It takes redirects (branch/jump targets) back from execute.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC value after reset.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch address (word aligned).
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_rsp_valid`  in  1  fetch response valid.
- `imem_rsp_data`  in  32  fetched instruction word.
- `imem_rsp_err`  in  1  access fault, qualified by `imem_rsp_valid`.
- `inst_valid_o`  out  1  instruction available to decode.
- `inst_o`  out  32  instruction word.
- `inst_addr_o`  out  32  PC of `inst_o`.
- `inst_ready_i`  in  1  decode accepts instruction this cycle.
- `jump_flag_i`  in  1  redirect request from execute.
- `jump_addr_i`  in  32  redirect target.
- `fetch_err_o`  out  1  sticky fetch fault (misaligned target or access fault).

## Operation
- Registers: `pc`, instruction buffer `ibuf`, `discard` flag, and a 4-state FSM: REQ, WAIT, HOLD, ERR.
- REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`. On `imem_req_ready`, go to WAIT. `imem_rsp_valid` is ignored in REQ.
- WAIT: on `imem_rsp_valid`:
  - If `discard`=1: drop the word, clear `discard`, go to REQ.
  - Else if `imem_rsp_err`: go to ERR.
  - Else: `ibuf`<=`imem_rsp_data` and go to HOLD.
- HOLD: `inst_valid_o`=1, `inst_o`=`ibuf`, `inst_addr_o`=`pc`. On `inst_ready_i`, `pc`<=`pc`+4 (mod 2^32) and go to REQ.
- ERR: `fetch_err_o`=1, no requests, `inst_valid_o`=0. The FSM leaves ERR only on reset.
- Redirect (`jump_flag_i`=1) has priority over every other event in the same cycle:
  - Target check: if `jump_addr_i[1:0]`≠0, go to ERR; `pc` is unchanged.
  - Otherwise `pc`<=`jump_addr_i`, with per-state action:
    - REQ without handshake: stay in REQ. The address changes next cycle; the memory side tolerates an address change on an unaccepted request.
    - REQ with handshake in the same cycle: go to WAIT with `discard`<=1.
    - WAIT without `imem_rsp_valid`: set `discard`<=1 and stay in WAIT.
    - WAIT with `imem_rsp_valid` in the same cycle: drop the word and go to REQ.
    - HOLD: drop `ibuf` and go to REQ. `inst_valid_o` is gated combinationally by `~jump_flag_i`, so no decode handshake occurs in a redirect cycle; `inst_ready_i` is ignored.
- At most one fetch is outstanding; responses return in order.
- `inst_o`/`inst_addr_o` stay stable while `inst_valid_o`=1 and no handshake has occurred.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - FSM=REQ, `pc`=`RESET_PC`, `ibuf`=0, `discard`=0.
  - Registered request-valid=0, so `imem_req_valid`=0 and `inst_valid_o`=0.
  - `fetch_err_o`=0, `inst_o`=0, `inst_addr_o`=`RESET_PC`.
- After reset release: `imem_req_valid`=1 from the first rising edge with `rst_n`=1.
- Zero-wait memory (`req_ready`=1, response one cycle after accept), decode always ready:
  - cycle 0: request accepted.
  - cycle 1: response, captured.
  - cycle 2: `inst_valid_o`=1, accepted.
  - cycle 3: next request.
  - Throughput: one instruction per 3 cycles.
- A response arrives at least one cycle after its request is accepted; arbitrary memory stall on either channel is tolerated.
- Redirect-to-first-request latency: 1 cycle from REQ or HOLD. From WAIT, 1 cycle after the stale response arrives.
- `pc` updates only on the decode handshake, a redirect, or reset.

## Test plan
- Reset/sequential: release reset with a zero-wait memory returning `addi` words, decode always ready. Required: requests at 0x80000000, 0x80000004, 0x80000008; each `inst_valid_o` pulse carries the matching address; 3-cycle spacing.
- Decode backpressure: hold `inst_ready_i`=0 for 5 cycles in HOLD. Required: `inst_o`/`inst_addr_o` stable, no new request; the request for `pc`+4 issues the cycle after ready rises.
- Redirect in WAIT: `jump_flag_i`=1, `jump_addr_i`=0x80000100 while a fetch of 0x80000004 is outstanding, response delayed 3 cycles. Required: the stale word is never presented; the next request is 0x80000100; the first valid instruction has `inst_addr_o`=0x80000100.
- Redirect coinciding with events: redirect in the same cycle as a `req_ready` handshake, and separately in the same cycle as `inst_ready_i`. Required: the stale response is discarded; `inst_valid_o`=0 in the redirect cycle; `pc` is not incremented.
- Faults: redirect to 0x80000102 -> `fetch_err_o`=1 next cycle and no further requests. Separately, `imem_rsp_err`=1 -> ERR state. Reset clears both.
- Asynchronous reset mid-WAIT: assert `rst_n`=0 between clock edges. Required: outputs reach reset values immediately, and fetch restarts at `RESET_PC`.
